// File: rtl/alu_decode_stage_if.sv
// Decode stage bundle: fetch-side valid/ready with instruction and flush,
// execute-side valid/ready with the decoded ALU fields.
interface alu_decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  alu_control;
  logic        alu_src_imm;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        reg_write;
  logic        branch;
  logic        branch_on_zero;
  logic        jump;
  logic        illegal;

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, alu_control, alu_src_imm, imm,
    input  rs1, rs2, rd, reg_write, branch, branch_on_zero, jump, illegal
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, alu_control, alu_src_imm, imm,
    output rs1, rs2, rd, reg_write, branch, branch_on_zero, jump, illegal
  );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32I registered decode stage: instr in (valid/ready) -> ALU fields out.
// Ports: clk, rst_n (async low), bus (slave). Macro: ALU_DECODE_ILLEGAL_EN.
module alu_decode_stage #(
  parameter logic [4:0] RESET_CTRL = 5'b00000
) (
  input logic clk,
  input logic rst_n,
  alu_decode_stage_if.slave bus
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  localparam logic [4:0] A_ADD  = 5'b00000;
  localparam logic [4:0] A_SUB  = 5'b00010;
  localparam logic [4:0] A_SLL  = 5'b00100;
  localparam logic [4:0] A_SLT  = 5'b01000;
  localparam logic [4:0] A_SLTU = 5'b01100;
  localparam logic [4:0] A_XOR  = 5'b10000;
  localparam logic [4:0] A_SRL  = 5'b10100;
  localparam logic [4:0] A_SRA  = 5'b10110;
  localparam logic [4:0] A_OR   = 5'b11000;
  localparam logic [4:0] A_BGE  = 5'b11010;
  localparam logic [4:0] A_AND  = 5'b11100;
  localparam logic [4:0] A_BGEU = 5'b11110;
  localparam logic [4:0] A_UPI  = 5'b11111;

  typedef struct packed {
    logic [4:0]  alu_control;
    logic        alu_src_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        branch;
    logic        branch_on_zero;
    logic        jump;
    logic        illegal;
  } dec_t;

  function automatic logic [4:0] f3_alu(
    input logic [2:0] f,
    input logic       alt
  );
    case (f)
      3'b000:  f3_alu = alt ? A_SUB : A_ADD;
      3'b001:  f3_alu = A_SLL;
      3'b010:  f3_alu = A_SLT;
      3'b011:  f3_alu = A_SLTU;
      3'b100:  f3_alu = A_XOR;
      3'b101:  f3_alu = alt ? A_SRA : A_SRL;
      3'b110:  f3_alu = A_OR;
      default: f3_alu = A_AND;
    endcase
  endfunction

  logic [31:0] i;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        shift_imm;
  logic        bad;
  logic        wr;
  logic        br;
  logic        jmp;
  dec_t        dec;
  dec_t        rst_val;
  dec_t        dec_d, dec_q;
  logic        valid_d, valid_q;
  logic        accept;

  assign i         = bus.in_instr;
  assign opc       = i[6:0];
  assign f3        = i[14:12];
  assign shift_imm = (f3 == 3'b001) || (f3 == 3'b101);

`ifdef ALU_DECODE_ILLEGAL_EN
  logic f7_bad;
  assign f7_bad = (i[31:25] != 7'h00) && (i[31:25] != 7'h20);

  always_comb begin
    bad = 1'b0;
    case (opc)
      OPC_OP:    bad = f7_bad;
      OPC_IMM:   bad = shift_imm && f7_bad;
      OPC_LOAD:  bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      OPC_STORE: bad = (f3 > 3'b010);
      OPC_BR:    bad = (f3[2:1] == 2'b01);
      OPC_LUI,
      OPC_AUIPC,
      OPC_JAL,
      OPC_JALR:  bad = 1'b0;
      default:   bad = 1'b1;
    endcase
  end
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    dec     = '0;
    wr      = 1'b0;
    br      = 1'b0;
    jmp     = 1'b0;
    dec.rs1 = i[19:15];
    dec.rs2 = i[24:20];
    dec.rd  = i[11:7];
    case (opc)
      OPC_OP: begin
        dec.alu_control = f3_alu(f3, i[30]);
        wr = 1'b1;
      end
      OPC_IMM: begin
        // ADDI ignores bit 30; only SRAI uses it
        dec.alu_control = f3_alu(f3, i[30] && (f3 == 3'b101));
        dec.alu_src_imm = 1'b1;
        dec.imm = shift_imm ? {27'b0, i[24:20]}
                            : {{20{i[31]}}, i[31:20]};
        wr = 1'b1;
      end
      OPC_LOAD, OPC_JALR: begin
        dec.alu_src_imm = 1'b1;
        dec.imm = {{20{i[31]}}, i[31:20]};
        wr  = 1'b1;
        jmp = (opc == OPC_JALR);
      end
      OPC_STORE: begin
        dec.alu_src_imm = 1'b1;
        dec.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      OPC_BR: begin
        dec.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        br = 1'b1;
        case (f3)
          3'b000:  dec.alu_control = A_SUB;
          3'b001:  dec.alu_control = A_SUB;
          3'b100:  dec.alu_control = A_SLT;
          3'b101:  dec.alu_control = A_BGE;
          3'b110:  dec.alu_control = A_SLTU;
          3'b111:  dec.alu_control = A_BGEU;
          default: br = 1'b0;
        endcase
        dec.branch_on_zero = (f3 == 3'b000);
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.alu_control = A_UPI;
        dec.alu_src_imm = 1'b1;
        dec.imm = {i[31:12], 12'b0};
        wr = 1'b1;
      end
      OPC_JAL: begin
        dec.alu_src_imm = 1'b1;
        dec.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        wr  = 1'b1;
        jmp = 1'b1;
      end
      default: ;
    endcase
    dec.illegal   = bad;
    dec.reg_write = wr && (dec.rd != 5'd0) && !bad;
    dec.branch    = br && !bad;
    dec.jump      = jmp && !bad;
  end

  assign bus.in_ready = !bus.flush && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    rst_val             = '0;
    rst_val.alu_control = RESET_CTRL;
    valid_d             = valid_q;
    dec_d               = dec_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      dec_d   = rst_val;
    end else if (accept) begin
      valid_d = 1'b1;
      dec_d   = dec;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q             <= 1'b0;
      dec_q               <= '0;
      dec_q.alu_control   <= RESET_CTRL;
    end else begin
      valid_q <= valid_d;
      dec_q   <= dec_d;
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.alu_control    = dec_q.alu_control;
  assign bus.alu_src_imm    = dec_q.alu_src_imm;
  assign bus.imm            = dec_q.imm;
  assign bus.rs1            = dec_q.rs1;
  assign bus.rs2            = dec_q.rs2;
  assign bus.rd             = dec_q.rd;
  assign bus.reg_write      = dec_q.reg_write;
  assign bus.branch         = dec_q.branch;
  assign bus.branch_on_zero = dec_q.branch_on_zero;
  assign bus.jump           = dec_q.jump;
  assign bus.illegal        = dec_q.illegal;

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered decode stage for the RV32I core that produces the 5-bit `ALU_control` code, operand-select flags and immediate consumed by the ALU in the execute stage. It accepts one 32-bit instruction per cycle over a valid/ready handshake and presents decoded fields one cycle later. It supports back-pressure (stall) and flush. It sits between instruction fetch and the execute stage.

## Interface
- `RESET_CTRL`, default `5'b00000`: value driven on `alu_control` at reset and after flush.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous reset, active low.
- `in_valid` input, 1 bit: instruction on `in_instr` is valid.
- `in_ready` output, 1 bit: stage can accept an instruction this cycle.
- `in_instr` input, 32 bits: RV32I instruction word.
- `flush` input, 1 bit: discard the held instruction and block acceptance this cycle.
- `out_valid` output, 1 bit: decoded fields are valid.
- `out_ready` input, 1 bit: execute stage consumes the fields this cycle.
- `alu_control` output, 5 bits: ALU operation code.
- `alu_src_imm` output, 1 bit: operand B is `imm` instead of rs2.
- `imm` output, 32 bits: sign-extended immediate.
- `rs1`, `rs2`, `rd` outputs, 5 bits each: register indices.
- `reg_write` output, 1 bit: the instruction writes `rd`.
- `branch` output, 1 bit: the instruction is a conditional branch.
- `branch_on_zero` output, 1 bit: branch is taken when the ALU `zero` flag is 1. When this bit is 0, the branch is taken when `zero` is 0.
- `jump` output, 1 bit: JAL or JALR.
- `illegal` output, 1 bit: unsupported encoding (see Configuration).

## Operation
ALU codes produced:

- **ADD `00000`:** ADD, ADDI, loads, stores, JAL, JALR.
- **SUB `00010`:** SUB, BEQ, BNE.
- **SLL `00100`:** SLL, SLLI.
- **SLT `01000`:** SLT, SLTI, BLT.
- **SLTU `01100`:** SLTU, SLTIU, BLTU.
- **XOR `10000`:** XOR, XORI.
- **SRL `10100`:** SRL, SRLI.
- **SRA `10110`:** SRA, SRAI.
- **OR `11000`:** OR, ORI.
- **BGE `11010`:** BGE.
- **AND `11100`:** AND, ANDI.
- **BGEU `11110`:** BGEU.
- **`11111`:** LUI, AUIPC.

Field selection:

- SUB vs ADD and SRA vs SRL are selected by `instr[30]`.
- For ADDI, `instr[30]` is ignored.
- `branch_on_zero` is 1 only for BEQ. BNE, BLT, BLTU, BGE and BGEU set it to 0.
- `reg_write` is 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR. It is 0 for all other instructions.
- `reg_write` is forced to 0 when `rd == 0`.

Immediate formats:

- I: `{{20{i[31]}}, i[31:20]}`.
- S: `i[31:25]` concatenated with `i[11:7]`.
- B: `{i[31], i[7], i[30:25], i[11:8], 0}`.
- U: `{i[31:12], 12'b0}`.
- J: `{i[31], i[19:12], i[20], i[30:21], 0}`.
- All formats are sign-extended to 32 bits.
- For shift-immediates, `imm = {27'b0, i[24:20]}`.

Unknown opcodes decode as ADD with `reg_write = 0`, `branch = 0` and `jump = 0`.

Handshake:

- `in_ready = !flush && (!out_valid || out_ready)`.
- An instruction is accepted when `in_valid && in_ready`. On acceptance all outputs load at the next edge and `out_valid` becomes 1.
- If `out_valid && out_ready` and there is no new acceptance, `out_valid` clears at the next edge.
- If `out_valid && !out_ready` (stall), all outputs hold stable.
- Flush has priority over everything. At the next edge `out_valid` becomes 0 and `alu_control` becomes `RESET_CTRL`. The input is not accepted in that cycle.

## Timing
- Latency is 1 cycle from acceptance to `out_valid`.
- Full throughput: 1 instruction per cycle while `out_ready` is held at 1.
- `in_ready` is combinational from `out_valid`, `out_ready` and `flush`. No other combinational path exists from input to output.
- Reset (asynchronous, any cycle, including mid-stall):
  - `out_valid` = 0, `alu_control` = `RESET_CTRL`.
  - `imm`, `rs1`, `rs2` and `rd` = 0.
  - All flags = 0, including `illegal`.
- After `rst_n` deasserts, the first acceptance is possible on the first clock edge.
- If flush and acceptance arrive in the same cycle, flush wins and the instruction is dropped. The upstream stage re-presents it because `in_ready` was 0.

## Configuration
- **`ALU_DECODE_ILLEGAL_EN` defined:** `illegal` is 1 when any of the following holds:
  - an unknown opcode;
  - `funct7` is neither `0000000` nor `0100000` on OP or shift-immediate instructions;
  - `funct3` is 010 or 011 on BRANCH;
  - the access width is illegal on LOAD or STORE.
- When `illegal` is 1, `reg_write`, `branch` and `jump` are forced to 0.
- `illegal` registers with the other fields.
- **`ALU_DECODE_ILLEGAL_EN` not defined:** `illegal` is tied to 0. There is no checking logic, and unknown encodings still decode as ADD with no writeback.

## Test plan
- **Reset:** reset asserted mid-stream → `out_valid` = 0, `alu_control` = `00000`, `in_ready` = 1 after release.
- **ADD/SUB:** ADD `0x002081B3` then SUB `0x402081B3` back-to-back with `out_ready` = 1 → codes `00000` then `00010` on consecutive cycles; `rd` = 3, `reg_write` = 1.
- **SRAI:** `0x40335293` → `alu_control` = `10110`, `imm` = 3, `alu_src_imm` = 1, `rd` = 5.
- **BLT:** `0x0020C463` → `alu_control` = `01000`, `branch` = 1, `branch_on_zero` = 0, `imm` = 8, `reg_write` = 0.
- **LUI with stall:** LUI `0x123450B7` with `out_ready` = 0 for 3 cycles → outputs hold `11111` and `imm` = `0x12345000`; `in_ready` = 0 throughout; released on the 4th cycle.
- **Flush:** flush while `out_valid` = 1 and `in_valid` = 1 → next cycle `out_valid` = 0; the instruction is not accepted. Separately, with the macro defined, opcode `0x7F` → `illegal` = 1 and `reg_write` = 0.
